// File: rtl/audio_packetizer.sv
// Packs multi-channel PCM frames into a ping-pong BRAM payload buffer behind a 16-bit
// sequence number and requests an Ethernet transmit each time a bank fills.
module audio_packetizer #(
   parameter int CHANNELS      = 2,
   parameter int SAMPLE_BYTES  = 2,
   parameter int HDR_BYTES     = 14,
   parameter int PAYLOAD_BYTES = 498,
   parameter int ADDR_W        = 10
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               sample_valid,
   input  logic [CHANNELS*SAMPLE_BYTES*8-1:0] sample_data,
   input  logic                               eth_busy,
   output logic                               eth_start,
   output logic                               tx_bank,
   output logic                               wr_en,
   output logic [ADDR_W-1:0]                  wr_addr,
   output logic [7:0]                         wr_data,
   output logic                               fill_bank,
   output logic [15:0]                        seq,
   output logic [15:0]                        overflow_cnt
);

   localparam int FRAME = CHANNELS * SAMPLE_BYTES;
   localparam int IW    = (FRAME > 1) ? $clog2(FRAME) : 1;
   localparam logic [ADDR_W-1:0] HDR_A    = ADDR_W'(HDR_BYTES);
   localparam logic [ADDR_W-1:0] END_A    = ADDR_W'(HDR_BYTES + PAYLOAD_BYTES);
   localparam logic [IW-1:0]     LAST_IDX = IW'(FRAME - 1);

   typedef enum logic [2:0] {
      S_SEQ_HI = 3'd0,
      S_SEQ_LO = 3'd1,
      S_IDLE   = 3'd2,
      S_WRITE  = 3'd3,
      S_COMMIT = 3'd4,
      S_LAUNCH = 3'd5
   } state_t;

   state_t              state, state_nx;
   logic                armed;
   logic                tx_inflight;
   logic                busy_q;
   logic                launch;
   logic                bank_full;
   logic [ADDR_W-1:0]   base;
   logic [ADDR_W-1:0]   ptr;
   logic [IW-1:0]       byte_idx;
   logic [FRAME*8-1:0]  frame;

   assign base      = {fill_bank, {(ADDR_W-1){1'b0}}};
   assign launch    = (state == S_LAUNCH) && !tx_inflight;
   // Sum truncates to ADDR_W so a payload ending exactly at the top of bank 1 wraps to 0.
   assign bank_full = (ptr == base + END_A);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_SEQ_HI;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_SEQ_HI: if (armed) state_nx = S_SEQ_LO;
         S_SEQ_LO: state_nx = S_IDLE;
         S_IDLE:   if (sample_valid) state_nx = S_WRITE;
         S_WRITE:  if (byte_idx == LAST_IDX) state_nx = S_COMMIT;
         S_COMMIT: state_nx = bank_full ? S_LAUNCH : S_IDLE;
         S_LAUNCH: if (!tx_inflight) state_nx = S_SEQ_HI;
         default:  state_nx = S_SEQ_HI;
      endcase
   end

   // armed keeps the write port quiet through reset; SEQ starts on the first edge after release.
   always_comb begin
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      eth_start = 1'b0;
      case (state)
         S_SEQ_HI: begin
            if (armed) begin
               wr_en   = 1'b1;
               wr_addr = base + HDR_A;
               wr_data = seq[15:8];
            end
         end
         S_SEQ_LO: begin
            wr_en   = 1'b1;
            wr_addr = base + HDR_A + ADDR_W'(1);
            wr_data = seq[7:0];
         end
         S_WRITE: begin
            wr_en   = 1'b1;
            wr_addr = ptr;
            wr_data = frame[{byte_idx, 3'b000} +: 8];
         end
         S_LAUNCH: eth_start = !tx_inflight;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed        <= 1'b0;
         tx_inflight  <= 1'b0;
         busy_q       <= 1'b0;
         tx_bank      <= 1'b0;
         fill_bank    <= 1'b0;
         seq          <= '0;
         overflow_cnt <= '0;
         ptr          <= '0;
         byte_idx     <= '0;
         frame        <= '0;
      end else begin
         armed  <= 1'b1;
         busy_q <= eth_busy;
         if (launch)                 tx_inflight <= 1'b1;
         else if (busy_q && !eth_busy) tx_inflight <= 1'b0;

         if (sample_valid && state != S_IDLE && overflow_cnt != 16'hFFFF)
            overflow_cnt <= overflow_cnt + 16'd1;

         case (state)
            S_SEQ_LO: ptr <= base + HDR_A + ADDR_W'(2);
            S_IDLE: begin
               if (sample_valid) begin
                  frame    <= sample_data;
                  byte_idx <= '0;
               end
            end
            S_WRITE: begin
               ptr      <= ptr + ADDR_W'(1);
               byte_idx <= byte_idx + IW'(1);
            end
            S_LAUNCH: begin
               if (!tx_inflight) begin
                  tx_bank   <= fill_bank;
                  fill_bank <= ~fill_bank;
                  seq       <= seq + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_audio_packetizer.sv
// Bench for audio_packetizer: a packet-level model predicts every BRAM write and
// transmit request; a monitor pops those predictions as the DUT produces them.
module tb_audio_packetizer;
   localparam int AW      = 10;
   localparam int HDR     = 14;
   localparam int PAYLOAD = 498;
   localparam int FRAME_B = 4;
   localparam int FPP     = (PAYLOAD - 2) / FRAME_B;
   localparam int W       = AW + 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sample_valid = 1'b0;
   logic [31:0]   sample_data = '0;
   logic          eth_busy = 1'b0;
   logic          eth_start, tx_bank, wr_en, fill_bank;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic [15:0]   seq, overflow_cnt;

   audio_packetizer dut (
      .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_data(sample_data),
      .eth_busy(eth_busy), .eth_start(eth_start), .tx_bank(tx_bank), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .fill_bank(fill_bank), .seq(seq),
      .overflow_cnt(overflow_cnt)
   );

   always #5 clk = ~clk;

   int            checks = 0;
   int            errors = 0;
   logic [W-1:0]  exp_q[$];
   logic          exp_start_q[$];
   bit            tx_chk_pending = 1'b0;
   logic          tx_chk_exp = 1'b0;
   int            starts_seen = 0;
   bit            hold_busy = 1'b0;
   int            busy_len = 4;
   logic [W-1:0]  mon_e;

   logic          m_bank;
   logic [15:0]   m_seq;
   int            m_frames;
   int            m_ovf;
   int            m_starts = 0;

   // Monitor: every write and every transmit request must match the next prediction.
   always @(negedge clk) begin
      if (tx_chk_pending) begin
         checks++;
         if (tx_bank !== tx_chk_exp) begin
            errors++;
            $display("FAIL tx_bank: got %0b expected %0b at %0t", tx_bank, tx_chk_exp, $time);
         end
         tx_chk_pending = 1'b0;
      end
      if (eth_start === 1'b1) begin
         starts_seen++;
         checks++;
         if (exp_start_q.size() == 0) begin
            errors++;
            $display("FAIL eth_start: unexpected pulse at %0t", $time);
         end else begin
            tx_chk_exp     = exp_start_q.pop_front();
            tx_chk_pending = 1'b1;
         end
      end
      if (wr_en === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected: got addr %0d data %02h, none expected at %0t",
                     wr_addr, wr_data, $time);
         end else begin
            mon_e = exp_q.pop_front();
            if ({wr_addr, wr_data} !== mon_e) begin
               errors++;
               $display("FAIL wr: got addr %0d data %02h expected addr %0d data %02h at %0t",
                        wr_addr, wr_data, mon_e[W-1:8], mon_e[7:0], $time);
            end
         end
      end
   end

   // Transmitter stand-in: busy a few cycles after each start, optionally held.
   always begin
      @(negedge clk);
      if (eth_start === 1'b1) begin
         repeat (2) @(negedge clk);
         eth_busy = 1'b1;
         repeat (busy_len) @(negedge clk);
         while (hold_busy) @(negedge clk);
         eth_busy = 1'b0;
      end
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   // ---------------- reference model ----------------
   task automatic push_seq();
      int b;
      b = m_bank ? (1 << (AW-1)) : 0;
      exp_q.push_back({AW'(b + HDR), m_seq[15:8]});
      exp_q.push_back({AW'(b + HDR + 1), m_seq[7:0]});
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_start_q.delete();
      tx_chk_pending = 1'b0;
      m_bank   = 1'b0;
      m_seq    = 16'd0;
      m_frames = 0;
      m_ovf    = 0;
      push_seq();
   endtask

   task automatic model_accept(input logic [31:0] f);
      logic [15:0] ch[2];
      int a;
      ch[0] = f[15:0];
      ch[1] = f[31:16];
      for (int c = 0; c < 2; c++) begin
         for (int b = 0; b < 2; b++) begin
            a = (m_bank ? (1 << (AW-1)) : 0) + HDR + 2 + m_frames * FRAME_B + c * 2 + b;
            exp_q.push_back({AW'(a), 8'(ch[c] >> (8 * b))});
         end
      end
      m_frames++;
      if (m_frames == FPP) begin
         exp_start_q.push_back(m_bank);
         m_starts++;
         m_bank   = ~m_bank;
         m_seq    = m_seq + 16'd1;
         m_frames = 0;
         push_seq();
      end
   endtask

   // ---------------- drivers ----------------
   task automatic send_frame(input logic [31:0] f);
      @(negedge clk);
      sample_data  = f;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic gap(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_accepted(input logic [31:0] f);
      model_accept(f);
      send_frame(f);
      gap($urandom_range(8, 11));
   endtask

   // Accepted frame followed by a strobe in its second write cycle.
   task automatic send_with_drop(input logic [31:0] f);
      model_accept(f);
      @(negedge clk);
      sample_data  = f;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      @(negedge clk);
      sample_data  = $urandom;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      m_ovf++;
      gap($urandom_range(8, 11));
   endtask

   task automatic wait_drain(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0 && exp_start_q.size() == 0 && !tx_chk_pending) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_reset(output bit ok);
      hold_busy = 1'b0;
      gap(30);
      rst_n        = 1'b0;
      sample_valid = 1'b0;
      model_reset();
      gap(3);
      rst_n = 1'b1;
      wait_drain(50, ok);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      bit ok;
      rst_n = 1'b0;
      gap(3);
      checks++;
      if ({eth_start, tx_bank, wr_en, wr_addr, wr_data, fill_bank, seq, overflow_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got wr_en %0b addr %0d data %02h seq %0d ovf %0d, expected all 0",
                  wr_en, wr_addr, wr_data, seq, overflow_cnt);
      end
      do_reset(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL reset_seq_drain: %0d writes still pending, expected 0", exp_q.size());
      end
      gap(3);
      checks++;
      if (wr_en !== 1'b0 || seq !== 16'd0 || overflow_cnt !== 16'd0 || fill_bank !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: got wr_en %0b seq %0d ovf %0d fill_bank %0b, expected 0 0 0 0",
                  wr_en, seq, overflow_cnt, fill_bank);
      end
   endtask

   task automatic test_one_frame();
      logic [7:0] exp_b[4];
      exp_b[0] = 8'h34; exp_b[1] = 8'h12; exp_b[2] = 8'hCD; exp_b[3] = 8'hAB;
      model_accept(32'hABCD1234);
      send_frame(32'hABCD1234);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         checks++;
         if (wr_en !== 1'b1 || wr_addr !== AW'(16 + k) || wr_data !== exp_b[k]) begin
            errors++;
            $display("FAIL one_frame_byte%0d: got en %0b addr %0d data %02h expected en 1 addr %0d data %02h",
                     k, wr_en, wr_addr, wr_data, 16 + k, exp_b[k]);
         end
      end
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0) begin
         errors++;
         $display("FAIL one_frame_commit: got wr_en %0b expected 0", wr_en);
      end
      gap(8);
   endtask

   task automatic test_full_bank();
      bit ok;
      hold_busy = 1'b1;
      for (int i = 1; i < FPP; i++) send_accepted($urandom);
      wait_drain(100, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL full_bank_drain: %0d writes %0d starts pending, expected 0 0",
                  exp_q.size(), exp_start_q.size());
      end
      checks++;
      if (starts_seen !== 1 || fill_bank !== 1'b1 || seq !== 16'd1) begin
         errors++;
         $display("FAIL full_bank_state: got starts %0d fill_bank %0b seq %0d expected 1 1 1",
                  starts_seen, fill_bank, seq);
      end
   endtask

   task automatic test_hold();
      bit ok;
      for (int i = 0; i < FPP; i++) send_accepted($urandom);
      for (int i = 0; i < 3; i++) begin
         send_frame($urandom);
         m_ovf++;
         gap(8);
      end
      checks++;
      if (starts_seen !== 1 || overflow_cnt !== 16'(m_ovf)) begin
         errors++;
         $display("FAIL hold_wait: got starts %0d ovf %0d expected 1 %0d", starts_seen, overflow_cnt, m_ovf);
      end
      checks++;
      if (exp_q.size() !== 2 || exp_start_q.size() !== 1) begin
         errors++;
         $display("FAIL hold_pending: got %0d writes %0d starts pending expected 2 1",
                  exp_q.size(), exp_start_q.size());
      end
      hold_busy = 1'b0;
      wait_drain(200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL hold_release_drain: %0d writes %0d starts pending expected 0 0",
                  exp_q.size(), exp_start_q.size());
      end
      checks++;
      if (starts_seen !== 2 || seq !== 16'd2 || fill_bank !== 1'b0) begin
         errors++;
         $display("FAIL hold_release_state: got starts %0d seq %0d fill_bank %0b expected 2 2 0",
                  starts_seen, seq, fill_bank);
      end
   endtask

   task automatic test_drop_in_write();
      bit ok;
      do_reset(ok);
      send_with_drop($urandom);
      send_accepted($urandom);
      wait_drain(50, ok);
      checks++;
      if (!ok || overflow_cnt !== 16'd1) begin
         errors++;
         $display("FAIL drop_in_write: got ovf %0d pending %0d expected ovf 1 pending 0",
                  overflow_cnt, exp_q.size());
      end
   endtask

   task automatic test_reset_mid_write();
      bit ok;
      logic [31:0] f;
      do_reset(ok);
      for (int i = 0; i < 49; i++) send_accepted($urandom);
      f = $urandom;
      model_accept(f);
      send_frame(f);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({eth_start, tx_bank, wr_en, wr_addr, wr_data, fill_bank, seq, overflow_cnt} !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got wr_en %0b addr %0d data %02h expected all 0",
                  wr_en, wr_addr, wr_data);
      end
      checks++;
      if (exp_q.size() !== 2) begin
         errors++;
         $display("FAIL mid_reset_partial: got %0d bytes unwritten expected 2", exp_q.size());
      end
      do_reset(ok);
      send_accepted($urandom);
      wait_drain(50, ok);
      checks++;
      if (!ok || seq !== 16'd0 || fill_bank !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_refill: got seq %0d fill_bank %0b pending %0d expected 0 0 0",
                  seq, fill_bank, exp_q.size());
      end
   endtask

   task automatic test_random();
      bit ok;
      do_reset(ok);
      for (int i = 0; i < 300; i++) begin
         busy_len = $urandom_range(1, 20);
         if ($urandom_range(0, 9) == 0) send_with_drop($urandom);
         else                           send_accepted($urandom);
      end
      wait_drain(200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL random_drain: %0d writes %0d starts pending expected 0 0",
                  exp_q.size(), exp_start_q.size());
      end
      checks++;
      if (overflow_cnt !== 16'(m_ovf) || seq !== m_seq || fill_bank !== m_bank || starts_seen !== m_starts) begin
         errors++;
         $display("FAIL random_state: got ovf %0d seq %0d bank %0b starts %0d expected %0d %0d %0b %0d",
                  overflow_cnt, seq, fill_bank, starts_seen, m_ovf, m_seq, m_bank, m_starts);
      end
   endtask

   initial begin
      test_reset();
      test_one_frame();
      test_full_bank();
      test_hold();
      test_drop_in_write();
      test_reset_mid_write();
      test_random();
      gap(5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
